// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative Y86-64 ALU sequencer.
//   - ifun encodings for the OPq family
//   - sequencer state enum and slice operation enum
//   - condition-code bit positions and reset value
package alu_pkg;

   localparam logic [3:0] IFUN_ADD = 4'd0;
   localparam logic [3:0] IFUN_SUB = 4'd1;
   localparam logic [3:0] IFUN_AND = 4'd2;
   localparam logic [3:0] IFUN_XOR = 4'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SOP_ADD = 2'd0,
      SOP_AND = 2'd1,
      SOP_XOR = 2'd2
   } slice_op_e;

   // Bit positions inside the {ZF,SF,OF} vector
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RESET = 3'b100;

   function automatic logic ifun_is_valid(input logic [3:0] f);
      return (f <= IFUN_XOR);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bus between execute-stage control (master)
// and the ALU sequencer (slave).
//
// Handshake rules (both channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The request fields (ifun, val_a, val_b, set_cc) matter only on that edge.
//   Once rsp_valid rises, result/err/cc stay stable until the transfer edge.
//   rsp_valid does not depend combinationally on rsp_ready.
interface alu_seq_if #(
   parameter int WIDTH = 64
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       ifun;
   logic [WIDTH-1:0] val_a;
   logic [WIDTH-1:0] val_b;
   logic             set_cc;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] result;
   logic             err;
   logic [2:0]       cc;

   modport master (
      output req_valid, ifun, val_a, val_b, set_cc, rsp_ready,
      input  req_ready, rsp_valid, result, err, cc
   );

   modport slave (
      input  req_valid, ifun, val_a, val_b, set_cc, rsp_ready,
      output req_ready, rsp_valid, result, err, cc
   );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: one SLICE-bit combinational add/and/xor slice.
// Ports:
//   op_i      slice operation (add / and / xor)
//   inv_y_i   invert y_i before adding (subtract: x + ~y + 1)
//   x_i, y_i  slice operands (x = val_b slice, y = val_a slice)
//   carry_i   carry-in from the previous slice
//   res_o     slice result
//   carry_o   carry-out (0 for logic ops)
module alu_slice
   import alu_pkg::*;
#(
   parameter int SLICE = 16
) (
   input  slice_op_e        op_i,
   input  logic             inv_y_i,
   input  logic [SLICE-1:0] x_i,
   input  logic [SLICE-1:0] y_i,
   input  logic             carry_i,
   output logic [SLICE-1:0] res_o,
   output logic             carry_o
);

   logic [SLICE-1:0] y_eff;
   logic [SLICE:0]   sum;

   always_comb begin
      y_eff   = inv_y_i ? ~y_i : y_i;
      sum     = {1'b0, x_i} + {1'b0, y_eff} + {{SLICE{1'b0}}, carry_i};
      res_o   = sum[SLICE-1:0];
      carry_o = 1'b0;
      case (op_i)
         SOP_ADD: begin
            res_o   = sum[SLICE-1:0];
            carry_o = sum[SLICE];
         end
         SOP_AND: res_o = x_i & y_i;
         SOP_XOR: res_o = x_i ^ y_i;
         default: res_o = sum[SLICE-1:0];
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: iterative WIDTH-bit ALU for the Y86-64 execute stage.
// One request is accepted in IDLE, processed SLICE bits per cycle through a
// single shared alu_slice, then returned in DONE with optional CC update.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   bus         alu_seq_if slave (request / response channels)
//   state_o     current FSM state (debug visibility)
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   alu_seq_if.slave bus,
   output state_e state_o
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   // Operands and result are stored slice-indexed so the counter selects
   // the active slice directly.
   typedef logic [NSLICE-1:0][SLICE-1:0] word_t;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       ifun_q, ifun_d;
   word_t            a_q, a_d;
   word_t            b_q, b_d;
   word_t            res_q, res_d;
   logic             set_cc_q, set_cc_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;
   logic [2:0]       cc_q, cc_d;

   slice_op_e        sop;
   logic [SLICE-1:0] slice_res;
   logic             slice_carry;
   word_t            res_fin;
   logic             last_slice;
   logic             r_sign, a_sign, b_sign, of_bit;

   always_comb begin
      case (ifun_q)
         IFUN_AND: sop = SOP_AND;
         IFUN_XOR: sop = SOP_XOR;
         default:  sop = SOP_ADD;
      endcase
   end

   alu_slice #(.SLICE(SLICE)) u_slice (
      .op_i    (sop),
      .inv_y_i (ifun_q == IFUN_SUB),
      .x_i     (b_q[cnt_q]),
      .y_i     (a_q[cnt_q]),
      .carry_i (carry_q),
      .res_o   (slice_res),
      .carry_o (slice_carry)
   );

   // Result including the slice being written this cycle; on the last slice
   // this is the complete word used for the condition codes.
   always_comb begin
      res_fin        = res_q;
      res_fin[cnt_q] = slice_res;
   end

   assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));
   assign r_sign     = res_fin[NSLICE-1][SLICE-1];
   assign a_sign     = a_q[NSLICE-1][SLICE-1];
   assign b_sign     = b_q[NSLICE-1][SLICE-1];

   always_comb begin
      case (ifun_q)
         IFUN_ADD: of_bit = (a_sign == b_sign) && (r_sign != a_sign);
         IFUN_SUB: of_bit = (a_sign != b_sign) && (r_sign != b_sign);
         default:  of_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ifun_d   = ifun_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      set_cc_d = set_cc_q;
      carry_d  = carry_q;
      err_d    = err_q;
      cc_d     = cc_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               ifun_d   = bus.ifun;
               a_d      = bus.val_a;
               b_d      = bus.val_b;
               set_cc_d = bus.set_cc;
               cnt_d    = '0;
               res_d    = '0;
               carry_d  = (bus.ifun == IFUN_SUB);
               if (ifun_is_valid(bus.ifun)) begin
                  err_d   = 1'b0;
                  state_d = ST_EXEC;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_EXEC: begin
            res_d   = res_fin;
            carry_d = slice_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_slice) begin
               cnt_d   = '0;
               state_d = ST_DONE;
               if (set_cc_q) begin
                  cc_d[CC_ZF] = (res_fin == '0);
                  cc_d[CC_SF] = r_sign;
                  cc_d[CC_OF] = of_bit;
               end
            end
         end
         ST_DONE: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ifun_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         set_cc_q <= 1'b0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
         cc_q     <= CC_RESET;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ifun_q   <= ifun_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         set_cc_q <= set_cc_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
         cc_q     <= cc_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_DONE);
   assign bus.result    = res_q;
   assign bus.err       = err_q;
   assign bus.cc        = cc_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
   import alu_pkg::*;

   localparam int WIDTH  = 64;
   localparam int SLICE  = 16;
   localparam int NSLICE = WIDTH / SLICE;

   typedef struct {
      logic [3:0]       ifun;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             set_cc;
      logic [WIDTH-1:0] exp_res;
      logic             exp_err;
      logic [2:0]       exp_cc;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_e dbg_state;

   alu_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [WIDTH+3:0] exp_q[$];
   vec_t tab[$];

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t lit(input logic [3:0] f, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic sc,
                                input logic [WIDTH-1:0] r, input logic e,
                                input logic [2:0] c);
      vec_t v;
      v.ifun = f; v.a = a; v.b = b; v.set_cc = sc;
      v.exp_res = r; v.exp_err = e; v.exp_cc = c;
      return v;
   endfunction

   // Whole-word reference: plain 64-bit arithmetic, sign rules from Y86-64.
   function automatic vec_t model(input logic [3:0] f, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic sc,
                                  input logic [2:0] prev_cc);
      vec_t v;
      logic [WIDTH-1:0] r;
      logic of;
      logic e;
      r = '0; of = 1'b0; e = 1'b0;
      case (f)
         4'd0: begin r = b + a; of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]); end
         4'd1: begin r = b - a; of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]); end
         4'd2: r = b & a;
         4'd3: r = b ^ a;
         default: e = 1'b1;
      endcase
      v = lit(f, a, b, sc, r, e,
              (sc && !e) ? {(r == '0), r[WIDTH-1], of} : prev_cc);
      return v;
   endfunction

   task automatic scramble_req();
      bus.ifun   = 4'($urandom_range(0, 15));
      bus.val_a  = {$urandom, $urandom};
      bus.val_b  = {$urandom, $urandom};
      bus.set_cc = 1'($urandom_range(0, 1));
   endtask

   // Drives one request, pushes its expectation, waits for the response and
   // compares. Leaves the bench sitting in DONE; the caller's rsp_ready
   // setting decides when it is consumed.
   task automatic run_op(input vec_t v, input string tag);
      int guard;
      int lat;
      logic [WIDTH+3:0] e;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check($sformatf("%s req_ready", tag), 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.ifun      = v.ifun;
      bus.val_a     = v.a;
      bus.val_b     = v.b;
      bus.set_cc    = v.set_cc;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      scramble_req();
      exp_q.push_back({v.exp_err, v.exp_cc, v.exp_res});
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check($sformatf("%s latency", tag), 64'(lat), v.exp_err ? 64'd0 : 64'(NSLICE));
      e = exp_q.pop_front();
      check($sformatf("%s result", tag), bus.result, e[WIDTH-1:0]);
      check($sformatf("%s err", tag), 64'(bus.err), 64'(e[WIDTH+3]));
      check($sformatf("%s cc", tag), 64'(bus.cc), 64'(e[WIDTH+2:WIDTH]));
   endtask

   initial begin
      logic [2:0] cc_prev;
      int rsp_seen;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.ifun      = '0;
      bus.val_a     = '0;
      bus.val_b     = '0;
      bus.set_cc    = 1'b0;

      // Reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset req_ready", 64'(bus.req_ready), 64'd1);
      check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset result", bus.result, 64'd0);
      check("reset err", 64'(bus.err), 64'd0);
      check("reset cc", 64'(bus.cc), 64'b100);
      check("reset state", 64'(dbg_state), 64'(ST_IDLE));
      rst_n = 1'b1;

      // Directed vectors
      tab.push_back(lit(IFUN_ADD, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                        64'h0, 1'b0, 3'b100));
      tab.push_back(lit(IFUN_SUB, 64'h1, 64'h8000_0000_0000_0000, 1'b1,
                        64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001));
      tab.push_back(lit(IFUN_XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
                        64'h1, 1'b0, 3'b000));
      tab.push_back(lit(IFUN_XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                        64'h0, 1'b0, 3'b000));
      tab.push_back(lit(IFUN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1,
                        64'h8000_0000_0000_0000, 1'b0, 3'b011));
      tab.push_back(lit(IFUN_AND, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1,
                        64'h0F0F_0000_0F0F_0000, 1'b0, 3'b000));
      tab.push_back(lit(IFUN_SUB, 64'h5, 64'h5, 1'b1,
                        64'h0, 1'b0, 3'b100));
      tab.push_back(lit(IFUN_SUB, 64'h0000_0000_0001_0000, 64'h0, 1'b0,
                        64'hFFFF_FFFF_FFFF_0000, 1'b0, 3'b100));
      // Random vectors through the reference model
      for (int i = 0; i < 10; i++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
         cc_prev = tab[tab.size()-1].exp_cc;
         tab.push_back(model(4'($urandom_range(0, 3)), ra, rb,
                             1'($urandom_range(0, 1)), cc_prev));
      end

      for (int i = 0; i < tab.size(); i++) begin
         run_op(tab[i], $sformatf("vec%0d", i));
      end
      cc_prev = tab[tab.size()-1].exp_cc;

      // Invalid op under backpressure; let the previous response drain first
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      run_op(lit(4'd7, 64'h1234, 64'h5678, 1'b1, 64'h0, 1'b1, cc_prev), "invalid");
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 1'b1;
         bus.ifun      = IFUN_ADD;
         bus.val_a     = {$urandom, $urandom};
         bus.val_b     = {$urandom, $urandom};
         bus.set_cc    = 1'b1;
         @(posedge clk); #1;
         check($sformatf("hold%0d rsp_valid", i), 64'(bus.rsp_valid), 64'd1);
         check($sformatf("hold%0d req_ready", i), 64'(bus.req_ready), 64'd0);
         check($sformatf("hold%0d result", i), bus.result, 64'd0);
         check($sformatf("hold%0d err", i), 64'(bus.err), 64'd1);
         check($sformatf("hold%0d cc", i), 64'(bus.cc), 64'(cc_prev));
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("release rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("release req_ready", 64'(bus.req_ready), 64'd1);

      // Put a non-reset value into cc, then reset in the middle of an addq
      run_op(lit(IFUN_SUB, 64'h1, 64'h8000_0000_0000_0000, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001), "pre_reset");
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.ifun      = IFUN_ADD;
      bus.val_a     = 64'h1;
      bus.val_b     = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.set_cc    = 1'b1;
      @(posedge clk); #1;             // accepted
      bus.req_valid = 1'b0;
      @(posedge clk); #1;             // slice 0 written
      @(posedge clk); #1;             // slice 1 written, slice 2 in progress
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst req_ready", 64'(bus.req_ready), 64'd1);
      check("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("midrst cc", 64'(bus.cc), 64'b100);
      check("midrst result", bus.result, 64'd0);
      rst_n = 1'b1;
      rsp_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid === 1'b1) rsp_seen++;
      end
      check("midrst no response", 64'(rsp_seen), 64'd0);

      run_op(lit(IFUN_XOR, 64'h3, 64'h5, 1'b1, 64'h6, 1'b0, 3'b000), "post_reset");
      @(posedge clk); #1;
      check("scoreboard empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
